aclock_ctrl: RTL and testbench
==============================

# aclock_ctrl

- User-interface sequencer that drives the `aclock` alarm-clock core.
- Turns single-cycle button pulses into time and alarm set sequences, and generates the `LD_time`/`LD_alarm` pulses with BCD load data.
- Handles snooze, dismiss, alarm-enable and ring timeout.
- Sits between the debounced button front-end and `aclock`, in the `clk` domain.

## Interface
- `SNOOZE_MIN`, default 5: minutes added to the current time on snooze. Legal range 1..59.
- `RING_TIMEOUT`, default 600: consecutive cycles of `Alarm`=1 (60 s at 10 Hz) before auto-dismiss. Minimum 2.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `btn_mode`, `btn_inc`, `btn_snooze`, `btn_stop`, `btn_alen`  in  1 each  debounced one-cycle button pulses.
- `Alarm`  in  1  ringing indication from `aclock`.
- `H_out1` (2), `H_out0` (4), `M_out1` (4), `M_out0` (4)  in  current BCD time from `aclock`.
- `H_in1` (2), `H_in0` (4), `M_in1` (4), `M_in0` (4)  out  BCD load data to `aclock`, registered.
- `LD_time`, `LD_alarm`, `STOP_al`  out  1 each  one-cycle registered pulses.
- `AL_ON`  out  1  alarm enable level.
- `state`  out  4  current FSM state code, for the display/blink logic.

## Operation
- **Edit register** `{eh1,eh0,em1,em0}`, all BCD.
- **Alarm shadow** `{ah1,ah0,am1,am0}` holds the user-set alarm.
  - Updated only on `LOAD_A`.
  - Snooze does not change it.
- **FSM states:**
  - `RUN`=0, `SET_TH`=1, `SET_TM`=2, `LOAD_T`=3, `SET_AH`=4, `SET_AM`=5, `LOAD_A`=6, `SNZ_STOP`=7, `SNZ_LOAD`=8, `DISMISS`=9, `RESTORE`=10.
- **Mode sequence:**
  - `RUN` + mode → `SET_TH`; the edit register loads from `H_out*`/`M_out*`.
  - `SET_TH` + mode → `SET_TM`.
  - `SET_TM` + mode → `LOAD_T`.
  - `LOAD_T` → `SET_AH` unconditionally; the edit register loads from the shadow.
  - `SET_AH` + mode → `SET_AM`.
  - `SET_AM` + mode → `LOAD_A`.
  - `LOAD_A` → `RUN`; the shadow is written.
- **inc:**
  - In `SET_TH`/`SET_AH`, hours increment 00..23 and wrap 23→00.
  - In `SET_TM`/`SET_AM`, minutes increment 00..59 and wrap 59→00, with no carry into hours.
  - Ignored in all other states.
- **Loads:**
  - `LOAD_T` drives the edit register on `H_in*`/`M_in*` with `LD_time`=1 in the same cycle.
  - `LOAD_A` does the same with `LD_alarm`=1.
- **Snooze:** accepted only in `RUN` with `Alarm`=1.
  - `SNZ_STOP`: `STOP_al`=1.
  - `SNZ_LOAD`: drives current time + `SNOOZE_MIN` with `LD_alarm`=1.
  - Minutes ≥60 subtract 60 and carry one hour; 23 + carry wraps to 00.
- **Stop:** accepted only in `RUN` with `Alarm`=1.
  - `DISMISS`: `STOP_al`=1.
  - `RESTORE`: drives the shadow with `LD_alarm`=1, which undoes any snooze.
  - Then returns to `RUN`.
- **Button priority** when several arrive in one cycle: snooze > stop > mode > inc. Lower-priority pulses are dropped.
- **btn_alen:** toggles `AL_ON` in any state, independent of the FSM.
- **Ring timeout:**
  - A counter increments while `Alarm`=1 and clears when `Alarm`=0.
  - When it reaches `RING_TIMEOUT` and the FSM is in `RUN`, the FSM enters `DISMISS` exactly as if stop had been pressed, and the counter clears.
  - In any other state the counter saturates until the FSM returns to `RUN`.
- Snooze and stop in set states are ignored; ringing continues.
- `H_in*`/`M_in*` hold their last driven value outside the load states.

## Timing
- **Reset values:**
  - `state`=`RUN`.
  - All outputs 0, including `AL_ON`=0 and `H_in*`/`M_in*`=00:00.
  - Shadow and edit register = 00:00; ring counter = 0.
- **Latencies:**
  - Button pulse at edge N → state change visible after edge N.
  - Load-state outputs are valid for exactly one cycle.
  - Snooze: `STOP_al` at cycle N+1, `LD_alarm` with data at N+2, back in `RUN` at N+3.
  - Stop follows the same timing as snooze.
  - `LOAD_T` and `LOAD_A` each last exactly one cycle.
- Load data and the LD pulse change in the same cycle; data is never stale against the pulse.
- Current time is sampled on the edge that accepts mode or snooze. A minute rollover in `aclock` after that edge is not reflected.
- Reset asserted mid-sequence aborts it immediately:
  - Any LD or STOP pulse in flight is cleared asynchronously.
  - No partial load completes.
  - The shadow returns to 00:00.

## Test plan
- Reset then mode, inc ×3, mode, inc ×2, mode starting from time 12:34 → `LD_time` one cycle with `H_in`=15, `M_in`=36; `state`=`SET_AH` next cycle.
- Hours wrap: start `SET_TH` at 22, inc ×2 → 00. Minutes: 58, inc ×2 → 00, hours unchanged.
- Alarm shadow 12:35, `AL_ON`=1, `Alarm`=1 at time 23:57, snooze → `STOP_al` at N+1; `LD_alarm` at N+2 with 00:02.
- After that snooze, `Alarm`=1 again, stop → `STOP_al`, then `LD_alarm` with 12:35.
- `Alarm` held high 600 cycles in `RUN` → `STOP_al` on cycle 601 and `LD_alarm` with the shadow; no action at 599.
- Snooze, mode and inc pulsed in the same cycle while ringing → snooze sequence only. Reset (`reset`=0) during `SNZ_STOP` → all outputs 0, `state`=`RUN`, `AL_ON`=0.

Source files
------------

// File: rtl/aclock_ctrl.sv
// UI sequencer for the aclock alarm-clock core: turns button pulses into time/alarm
// set sequences, snooze/dismiss handling and LD_time/LD_alarm load pulses with BCD data.
module aclock_ctrl #(
    parameter int unsigned SNOOZE_MIN   = 5,
    parameter int unsigned RING_TIMEOUT = 600
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       btn_snooze,
    input  logic       btn_stop,
    input  logic       btn_alen,
    input  logic       Alarm,
    input  logic [1:0] H_out1,
    input  logic [3:0] H_out0,
    input  logic [3:0] M_out1,
    input  logic [3:0] M_out0,
    output logic [1:0] H_in1,
    output logic [3:0] H_in0,
    output logic [3:0] M_in1,
    output logic [3:0] M_in0,
    output logic       LD_time,
    output logic       LD_alarm,
    output logic       STOP_al,
    output logic       AL_ON,
    output logic [3:0] state
);

    localparam int unsigned TIME_W = 14;
    localparam int unsigned CNT_W  = $clog2(RING_TIMEOUT + 1);

    localparam logic [3:0] S_RUN      = 4'd0;
    localparam logic [3:0] S_SET_TH   = 4'd1;
    localparam logic [3:0] S_SET_TM   = 4'd2;
    localparam logic [3:0] S_LOAD_T   = 4'd3;
    localparam logic [3:0] S_SET_AH   = 4'd4;
    localparam logic [3:0] S_SET_AM   = 4'd5;
    localparam logic [3:0] S_LOAD_A   = 4'd6;
    localparam logic [3:0] S_SNZ_STOP = 4'd7;
    localparam logic [3:0] S_SNZ_LOAD = 4'd8;
    localparam logic [3:0] S_DISMISS  = 4'd9;
    localparam logic [3:0] S_RESTORE  = 4'd10;

    localparam logic [CNT_W-1:0] CNT_TRIG = CNT_W'(RING_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(RING_TIMEOUT);

    // Time values are packed BCD {h1[1:0], h0, m1, m0}
    logic [3:0]        state_q, state_d;
    logic [TIME_W-1:0] edit_q, edit_d;
    logic [TIME_W-1:0] shadow_q, shadow_d;
    logic [TIME_W-1:0] ld_in_q, ld_in_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ld_time_q, ld_time_d;
    logic              ld_alarm_q, ld_alarm_d;
    logic              stop_al_q, stop_al_d;
    logic              al_on_q, al_on_d;

    logic [TIME_W-1:0] time_now;
    logic              ring_in_run;
    logic              timeout;

    function automatic logic [7:0] to_bcd(input logic [6:0] v);
        logic [3:0] tens;
        logic [6:0] rem;
        tens = 4'd0;
        rem  = v;
        for (int i = 0; i < 11; i++) begin
            if (rem >= 7'd10) begin
                rem  = rem - 7'd10;
                tens = tens + 4'd1;
            end
        end
        return {tens, rem[3:0]};
    endfunction

    function automatic logic [TIME_W-1:0] inc_hours(input logic [TIME_W-1:0] t);
        logic [1:0] h1;
        logic [3:0] h0;
        h1 = t[13:12];
        h0 = t[11:8];
        if (h1 == 2'd2 && h0 == 4'd3) begin
            h1 = 2'd0;
            h0 = 4'd0;
        end else if (h0 == 4'd9) begin
            h1 = h1 + 2'd1;
            h0 = 4'd0;
        end else begin
            h0 = h0 + 4'd1;
        end
        return {h1, h0, t[7:0]};
    endfunction

    // Minutes wrap 59 -> 00 without touching the hours
    function automatic logic [TIME_W-1:0] inc_minutes(input logic [TIME_W-1:0] t);
        logic [3:0] m1;
        logic [3:0] m0;
        m1 = t[7:4];
        m0 = t[3:0];
        if (m0 == 4'd9) begin
            m0 = 4'd0;
            m1 = (m1 == 4'd5) ? 4'd0 : m1 + 4'd1;
        end else begin
            m0 = m0 + 4'd1;
        end
        return {t[13:8], m1, m0};
    endfunction

    function automatic logic [TIME_W-1:0] snooze_add(input logic [TIME_W-1:0] t);
        logic [6:0] mins;
        logic [6:0] hrs;
        logic [7:0] mb;
        logic [7:0] hb;
        mins = 7'(t[7:4]) * 7'd10 + 7'(t[3:0]) + 7'(SNOOZE_MIN);
        hrs  = 7'(t[13:12]) * 7'd10 + 7'(t[11:8]);
        if (mins >= 7'd60) begin
            mins = mins - 7'd60;
            hrs  = hrs + 7'd1;
        end
        if (hrs >= 7'd24) begin
            hrs = 7'd0;
        end
        mb = to_bcd(mins);
        hb = to_bcd(hrs);
        return {hb[5:4], hb[3:0], mb};
    endfunction

    assign time_now    = {H_out1, H_out0, M_out1, M_out0};
    assign ring_in_run = (state_q == S_RUN) && Alarm;
    assign timeout     = ring_in_run && (cnt_q >= CNT_TRIG);

    // Next-state, edit/shadow registers, ring counter and registered outputs
    always_comb begin
        state_d    = state_q;
        edit_d     = edit_q;
        shadow_d   = shadow_q;
        ld_in_d    = ld_in_q;
        cnt_d      = cnt_q;
        al_on_d    = al_on_q ^ btn_alen;
        ld_time_d  = 1'b0;
        ld_alarm_d = 1'b0;
        stop_al_d  = 1'b0;

        if (!Alarm || timeout) begin
            cnt_d = '0;
        end else if (cnt_q < CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        case (state_q)
            S_RUN: begin
                if (ring_in_run && btn_snooze) begin
                    state_d = S_SNZ_STOP;
                    edit_d  = time_now;
                end else if ((ring_in_run && btn_stop) || timeout) begin
                    state_d = S_DISMISS;
                end else if (btn_mode) begin
                    state_d = S_SET_TH;
                    edit_d  = time_now;
                end
            end
            S_SET_TH: begin
                if (btn_mode)     state_d = S_SET_TM;
                else if (btn_inc) edit_d  = inc_hours(edit_q);
            end
            S_SET_TM: begin
                if (btn_mode)     state_d = S_LOAD_T;
                else if (btn_inc) edit_d  = inc_minutes(edit_q);
            end
            S_LOAD_T: begin
                state_d = S_SET_AH;
                edit_d  = shadow_q;
            end
            S_SET_AH: begin
                if (btn_mode)     state_d = S_SET_AM;
                else if (btn_inc) edit_d  = inc_hours(edit_q);
            end
            S_SET_AM: begin
                if (btn_mode)     state_d = S_LOAD_A;
                else if (btn_inc) edit_d  = inc_minutes(edit_q);
            end
            S_LOAD_A: begin
                state_d  = S_RUN;
                shadow_d = edit_q;
            end
            S_SNZ_STOP: state_d = S_SNZ_LOAD;
            S_SNZ_LOAD: state_d = S_RUN;
            S_DISMISS:  state_d = S_RESTORE;
            S_RESTORE:  state_d = S_RUN;
            default:    state_d = S_RUN;
        endcase

        // Pulses and load data are registered from the state being entered
        if (state_d == S_LOAD_T || state_d == S_LOAD_A) begin
            ld_in_d = edit_q;
        end else if (state_d == S_SNZ_LOAD) begin
            ld_in_d = snooze_add(edit_q);
        end else if (state_d == S_RESTORE) begin
            ld_in_d = shadow_q;
        end
        ld_time_d  = (state_d == S_LOAD_T);
        ld_alarm_d = (state_d == S_LOAD_A) || (state_d == S_SNZ_LOAD) || (state_d == S_RESTORE);
        stop_al_d  = (state_d == S_SNZ_STOP) || (state_d == S_DISMISS);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_RUN;
            edit_q     <= '0;
            shadow_q   <= '0;
            ld_in_q    <= '0;
            cnt_q      <= '0;
            ld_time_q  <= 1'b0;
            ld_alarm_q <= 1'b0;
            stop_al_q  <= 1'b0;
            al_on_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            edit_q     <= edit_d;
            shadow_q   <= shadow_d;
            ld_in_q    <= ld_in_d;
            cnt_q      <= cnt_d;
            ld_time_q  <= ld_time_d;
            ld_alarm_q <= ld_alarm_d;
            stop_al_q  <= stop_al_d;
            al_on_q    <= al_on_d;
        end
    end

    assign H_in1    = ld_in_q[13:12];
    assign H_in0    = ld_in_q[11:8];
    assign M_in1    = ld_in_q[7:4];
    assign M_in0    = ld_in_q[3:0];
    assign LD_time  = ld_time_q;
    assign LD_alarm = ld_alarm_q;
    assign STOP_al  = stop_al_q;
    assign AL_ON    = al_on_q;
    assign state    = state_q;

endmodule

// File: tb/tb_aclock_ctrl.sv
// Directed bench for aclock_ctrl: vector table for set/snooze/stop flows, plus
// hand-written ring-timeout and mid-sequence reset sequences.
module tb_aclock_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_mode, btn_inc, btn_snooze, btn_stop, btn_alen;
    logic       Alarm;
    logic [1:0] H_out1;
    logic [3:0] H_out0, M_out1, M_out0;
    logic [1:0] H_in1;
    logic [3:0] H_in0, M_in1, M_in0;
    logic       LD_time, LD_alarm, STOP_al, AL_ON;
    logic [3:0] state;

    int checks   = 0;
    int failures = 0;

    localparam logic [4:0] B_MODE = 5'b10000;
    localparam logic [4:0] B_INC  = 5'b01000;
    localparam logic [4:0] B_SNZ  = 5'b00100;
    localparam logic [4:0] B_STOP = 5'b00010;
    localparam logic [4:0] B_ALEN = 5'b00001;

    typedef struct {
        logic [4:0]  btn;
        logic        alarm;
        logic [13:0] t_now;
        int          reps;
        logic [3:0]  st;
        logic [3:0]  flags;   // {LD_time, LD_alarm, STOP_al, AL_ON}
        logic [13:0] data;
    } vec_t;

    vec_t tbl[$];

    aclock_ctrl #(.SNOOZE_MIN(5), .RING_TIMEOUT(600)) dut (
        .clk(clk), .reset(reset),
        .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_snooze(btn_snooze),
        .btn_stop(btn_stop), .btn_alen(btn_alen), .Alarm(Alarm),
        .H_out1(H_out1), .H_out0(H_out0), .M_out1(M_out1), .M_out0(M_out0),
        .H_in1(H_in1), .H_in0(H_in0), .M_in1(M_in1), .M_in0(M_in0),
        .LD_time(LD_time), .LD_alarm(LD_alarm), .STOP_al(STOP_al),
        .AL_ON(AL_ON), .state(state)
    );

    always #5 clk = ~clk;

    function automatic logic [13:0] bcd(input int h, input int m);
        return {2'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10)};
    endfunction

    function automatic vec_t mk(input logic [4:0] b, input logic a, input logic [13:0] t,
                                input int r, input logic [3:0] s, input logic [3:0] f,
                                input logic [13:0] d);
        vec_t v;
        v.btn = b; v.alarm = a; v.t_now = t; v.reps = r;
        v.st = s; v.flags = f; v.data = d;
        return v;
    endfunction

    function automatic logic [21:0] observed();
        return {state, LD_time, LD_alarm, STOP_al, AL_ON, H_in1, H_in0, M_in1, M_in0};
    endfunction

    task automatic check(input string name, input logic [21:0] got, input logic [21:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h (state,flags,bcd)", name, got, exp);
        end
    endtask

    task automatic drive(input logic [4:0] b, input logic a, input logic [13:0] t);
        {btn_mode, btn_inc, btn_snooze, btn_stop, btn_alen} = b;
        Alarm = a;
        {H_out1, H_out0, M_out1, M_out0} = t;
    endtask

    // One clock with the given inputs, then sample 1 ns after the edge
    task automatic step_chk(input string name, input logic [4:0] b, input logic a,
                            input logic [13:0] t, input logic [3:0] s,
                            input logic [3:0] f, input logic [13:0] d);
        drive(b, a, t);
        @(posedge clk);
        #1;
        {btn_mode, btn_inc, btn_snooze, btn_stop, btn_alen} = 5'b0;
        check(name, observed(), {s, f, d});
    endtask

    initial begin
        int bad;
        reset = 1'b0;
        drive(5'b0, 1'b0, bcd(0, 0));
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", observed(), 22'h0);
        reset = 1'b1;

        // Set time 12:34 -> 15:36, then set the alarm shadow to 12:35
        tbl.push_back(mk(B_MODE, 0, bcd(12,34), 1,  1, 4'b0000, bcd(0,0)));
        tbl.push_back(mk(B_INC,  0, bcd(12,34), 3,  1, 4'b0000, bcd(0,0)));
        tbl.push_back(mk(B_MODE, 0, bcd(12,34), 1,  2, 4'b0000, bcd(0,0)));
        tbl.push_back(mk(B_INC,  0, bcd(12,34), 2,  2, 4'b0000, bcd(0,0)));
        tbl.push_back(mk(B_MODE, 0, bcd(12,34), 1,  3, 4'b1000, bcd(15,36)));
        tbl.push_back(mk(5'b0,   0, bcd(12,34), 1,  4, 4'b0000, bcd(15,36)));
        tbl.push_back(mk(B_INC,  0, bcd(12,34), 12, 4, 4'b0000, bcd(15,36)));
        tbl.push_back(mk(B_MODE, 0, bcd(12,34), 1,  5, 4'b0000, bcd(15,36)));
        tbl.push_back(mk(B_INC,  0, bcd(12,34), 35, 5, 4'b0000, bcd(15,36)));
        tbl.push_back(mk(B_MODE, 0, bcd(12,34), 1,  6, 4'b0100, bcd(12,35)));
        tbl.push_back(mk(5'b0,   0, bcd(12,34), 1,  0, 4'b0000, bcd(12,35)));
        tbl.push_back(mk(B_ALEN, 0, bcd(12,34), 1,  0, 4'b0001, bcd(12,35)));
        // Snooze at 23:57 with mode+inc in the same cycle; time moves after the accept edge
        tbl.push_back(mk(B_SNZ | B_MODE | B_INC, 1, bcd(23,57), 1, 7, 4'b0011, bcd(12,35)));
        tbl.push_back(mk(5'b0,   1, bcd(23,58), 1,  8, 4'b0101, bcd(0,2)));
        tbl.push_back(mk(5'b0,   0, bcd(23,58), 1,  0, 4'b0001, bcd(0,2)));
        // Stop restores the shadow
        tbl.push_back(mk(B_STOP, 1, bcd(23,58), 1,  9, 4'b0011, bcd(0,2)));
        tbl.push_back(mk(5'b0,   1, bcd(23,58), 1, 10, 4'b0101, bcd(12,35)));
        tbl.push_back(mk(5'b0,   0, bcd(23,58), 1,  0, 4'b0001, bcd(12,35)));
        // Snooze/stop without Alarm are ignored
        tbl.push_back(mk(B_SNZ,  0, bcd(23,58), 1,  0, 4'b0001, bcd(12,35)));
        tbl.push_back(mk(B_STOP, 0, bcd(23,58), 1,  0, 4'b0001, bcd(12,35)));
        // Hour wrap 22->23->00, minute wrap 58->59->00->01 with no hour carry
        tbl.push_back(mk(B_MODE, 0, bcd(22,58), 1,  1, 4'b0001, bcd(12,35)));
        tbl.push_back(mk(B_INC,  0, bcd(22,58), 2,  1, 4'b0001, bcd(12,35)));
        tbl.push_back(mk(B_MODE, 0, bcd(22,58), 1,  2, 4'b0001, bcd(12,35)));
        tbl.push_back(mk(B_INC,  0, bcd(22,58), 3,  2, 4'b0001, bcd(12,35)));
        tbl.push_back(mk(B_MODE, 0, bcd(22,58), 1,  3, 4'b1001, bcd(0,1)));
        tbl.push_back(mk(5'b0,   0, bcd(22,58), 1,  4, 4'b0001, bcd(0,1)));
        tbl.push_back(mk(B_MODE, 0, bcd(22,58), 1,  5, 4'b0001, bcd(0,1)));
        tbl.push_back(mk(B_MODE, 0, bcd(22,58), 1,  6, 4'b0101, bcd(12,35)));
        tbl.push_back(mk(5'b0,   0, bcd(22,58), 1,  0, 4'b0001, bcd(12,35)));
        tbl.push_back(mk(B_INC,  0, bcd(22,58), 1,  0, 4'b0001, bcd(12,35)));
        tbl.push_back(mk(B_ALEN, 0, bcd(22,58), 1,  0, 4'b0000, bcd(12,35)));
        tbl.push_back(mk(B_ALEN, 0, bcd(22,58), 1,  0, 4'b0001, bcd(12,35)));
        // Snooze/stop inside a set state are ignored
        tbl.push_back(mk(B_MODE, 0, bcd(22,58), 1,  1, 4'b0001, bcd(12,35)));
        tbl.push_back(mk(B_SNZ,  1, bcd(22,58), 1,  1, 4'b0001, bcd(12,35)));
        tbl.push_back(mk(B_STOP, 1, bcd(22,58), 1,  1, 4'b0001, bcd(12,35)));
        tbl.push_back(mk(B_MODE, 0, bcd(22,58), 1,  2, 4'b0001, bcd(12,35)));
        tbl.push_back(mk(B_MODE, 0, bcd(22,58), 1,  3, 4'b1001, bcd(22,58)));
        tbl.push_back(mk(5'b0,   0, bcd(22,58), 1,  4, 4'b0001, bcd(22,58)));
        tbl.push_back(mk(B_MODE, 0, bcd(22,58), 1,  5, 4'b0001, bcd(22,58)));
        tbl.push_back(mk(B_MODE, 0, bcd(22,58), 1,  6, 4'b0101, bcd(12,35)));
        tbl.push_back(mk(5'b0,   0, bcd(22,58), 1,  0, 4'b0001, bcd(12,35)));

        foreach (tbl[i]) begin
            for (int r = 0; r < tbl[i].reps; r++) begin
                step_chk($sformatf("vec%0d_rep%0d", i, r), tbl[i].btn, tbl[i].alarm,
                         tbl[i].t_now, tbl[i].st, tbl[i].flags, tbl[i].data);
            end
        end

        // Ring timeout: 599 cycles do nothing, 600 trigger dismiss + restore
        bad = 0;
        for (int k = 0; k < 599; k++) begin
            drive(5'b0, 1'b1, bcd(7,0));
            @(posedge clk);
            #1;
            if (observed() !== {4'd0, 4'b0001, bcd(12,35)}) bad++;
        end
        check("timeout_599_quiet", 22'(bad), 22'd0);
        step_chk("timeout_gap", 5'b0, 1'b0, bcd(7,0), 4'd0, 4'b0001, bcd(12,35));
        bad = 0;
        for (int k = 0; k < 599; k++) begin
            drive(5'b0, 1'b1, bcd(7,0));
            @(posedge clk);
            #1;
            if (observed() !== {4'd0, 4'b0001, bcd(12,35)}) bad++;
        end
        check("timeout_pre_quiet", 22'(bad), 22'd0);
        step_chk("timeout_dismiss", 5'b0, 1'b1, bcd(7,0), 4'd9, 4'b0011, bcd(12,35));
        step_chk("timeout_restore", 5'b0, 1'b1, bcd(7,0), 4'd10, 4'b0101, bcd(12,35));
        step_chk("timeout_run", 5'b0, 1'b0, bcd(7,0), 4'd0, 4'b0001, bcd(12,35));

        // Reset asserted while in SNZ_STOP clears everything asynchronously
        step_chk("rst_snz_stop", B_SNZ, 1'b1, bcd(10,10), 4'd7, 4'b0011, bcd(12,35));
        #2;
        reset = 1'b0;
        #1;
        check("rst_async_clear", observed(), 22'h0);
        @(posedge clk);
        #1;
        check("rst_held", observed(), 22'h0);
        reset = 1'b1;

        // Shadow back to 00:00: snooze from 10:10, then stop restores 00:00
        step_chk("post_snz", B_SNZ, 1'b1, bcd(10,10), 4'd7, 4'b0010, bcd(0,0));
        step_chk("post_snz_ld", 5'b0, 1'b1, bcd(10,10), 4'd8, 4'b0100, bcd(10,15));
        step_chk("post_snz_run", 5'b0, 1'b0, bcd(10,10), 4'd0, 4'b0000, bcd(10,15));
        step_chk("post_stop", B_STOP, 1'b1, bcd(10,10), 4'd9, 4'b0010, bcd(10,15));
        step_chk("post_restore", 5'b0, 1'b1, bcd(10,10), 4'd10, 4'b0100, bcd(0,0));
        step_chk("post_run", 5'b0, 1'b0, bcd(10,10), 4'd0, 4'b0000, bcd(0,0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
